// File: rtl/fp_cmp_pkg.sv
// Shared types and constants for the RV32F compare / min-max execution stage.
// Operation encodings, operand classification record and flag bit positions.
package fp_cmp_pkg;

    typedef enum logic [2:0] {
        FP_FMIN = 3'd0,
        FP_FMAX = 3'd1,
        FP_FEQ  = 3'd2,
        FP_FLT  = 3'd3,
        FP_FLE  = 3'd4
    } fp_cmp_op_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int          FFLAG_NV  = 4;

    typedef struct packed {
        logic sign;
        logic is_nan;
        logic is_snan;
        logic is_zero;
    } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// Flags NaN / signalling NaN / zero and passes the sign bit through.
module fp_classify
    import fp_cmp_pkg::*;
(
    input  logic [31:0] val,
    output fp_class_t   cls
);

    logic exp_ones;
    logic exp_zero;
    logic man_nz;

    assign exp_ones = &val[30:23];
    assign exp_zero = ~|val[30:23];
    assign man_nz   = |val[22:0];

    assign cls.sign    = val[31];
    assign cls.is_nan  = exp_ones & man_nz;
    assign cls.is_snan = exp_ones & man_nz & ~val[22];
    assign cls.is_zero = exp_zero & ~man_nz;

endmodule

// File: rtl/fp_cmp_stage.sv
// Two-stage pipelined RV32F FMIN/FMAX/FEQ/FLT/FLE unit with valid/ready flow control.
// S1 holds classified operands plus a magnitude compare; S2 holds the final result and flags.
module fp_cmp_stage
    import fp_cmp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic [4:0]       fflags_o,
    output logic [TAG_W-1:0] tag_o
);

    // Ordering is sign-magnitude on {exp,man}; zeros tie only for the compare ops.
    function automatic logic [36:0] select_result(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input fp_class_t   ca,
        input fp_class_t   cb,
        input logic        lt_mag,
        input logic        eq_mag
    );
        logic        both_zero;
        logic        any_nan;
        logic        any_snan;
        logic        a_lt_tot;
        logic        a_eq_tot;
        logic        a_lt;
        logic        a_eq;
        logic [31:0] res;
        logic [4:0]  flg;
        both_zero = ca.is_zero & cb.is_zero;
        any_nan   = ca.is_nan | cb.is_nan;
        any_snan  = ca.is_snan | cb.is_snan;
        if (ca.sign != cb.sign) a_lt_tot = ca.sign;
        else if (ca.sign)       a_lt_tot = ~lt_mag & ~eq_mag;
        else                    a_lt_tot = lt_mag;
        a_eq_tot = (ca.sign == cb.sign) & eq_mag;
        a_lt     = a_lt_tot & ~both_zero;
        a_eq     = a_eq_tot | both_zero;
        res = '0;
        flg = '0;
        case (op)
            FP_FMIN, FP_FMAX: begin
                if (ca.is_nan & cb.is_nan) res = CANON_NAN;
                else if (ca.is_nan)        res = b;
                else if (cb.is_nan)        res = a;
                else if (op == FP_FMIN)    res = (a_lt_tot | a_eq_tot) ? a : b;
                else                       res = a_lt_tot ? b : a;
                flg[FFLAG_NV] = any_snan;
            end
            FP_FEQ: begin
                res[0]        = ~any_nan & a_eq;
                flg[FFLAG_NV] = any_snan;
            end
            FP_FLT: begin
                res[0]        = ~any_nan & a_lt;
                flg[FFLAG_NV] = any_nan;
            end
            FP_FLE: begin
                res[0]        = ~any_nan & (a_lt | a_eq);
                flg[FFLAG_NV] = any_nan;
            end
            default: ;
        endcase
        return {res, flg};
    endfunction

    fp_class_t cls_a;
    fp_class_t cls_b;

    fp_classify u_cls_a (.val(rs1_i), .cls(cls_a));
    fp_classify u_cls_b (.val(rs2_i), .cls(cls_b));

    logic             vld_p1;
    logic             vld_p2;
    logic             s1_adv;
    logic             s2_adv;
    logic [2:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [31:0]      a_p1;
    logic [31:0]      b_p1;
    fp_class_t        cls_a_p1;
    fp_class_t        cls_b_p1;
    logic             lt_mag_p1;
    logic             eq_mag_p1;
    logic [31:0]      result_p2;
    logic [4:0]       fflags_p2;
    logic [TAG_W-1:0] tag_p2;
    logic [36:0]      sel_p1;

    assign s2_adv     = ~vld_p2 | out_ready_i;
    assign s1_adv     = ~vld_p1 | s2_adv;
    assign in_ready_o = s1_adv & ~flush_i;

    // S1: capture operands, their classes and the unsigned magnitude compare
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid_i) begin
            op_p1     <= op_i;
            tag_p1    <= tag_i;
            a_p1      <= rs1_i;
            b_p1      <= rs2_i;
            cls_a_p1  <= cls_a;
            cls_b_p1  <= cls_b;
            lt_mag_p1 <= rs1_i[30:0] < rs2_i[30:0];
            eq_mag_p1 <= rs1_i[30:0] == rs2_i[30:0];
        end
    end

    assign sel_p1 = select_result(op_p1, a_p1, b_p1, cls_a_p1, cls_b_p1, lt_mag_p1, eq_mag_p1);

    // S2: final result register driving the output ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            fflags_p2 <= '0;
            tag_p2    <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv) vld_p1 <= in_valid_i;
            if (s2_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    result_p2 <= sel_p1[36:5];
                    fflags_p2 <= sel_p1[4:0];
                    tag_p2    <= tag_p1;
                end
            end
        end
    end

    assign out_valid_o = vld_p2;
    assign result_o    = result_p2;
    assign fflags_o    = fflags_p2;
    assign tag_o       = tag_p2;

endmodule

// File: tb/tb_fp_cmp_stage.sv
// Directed scoreboard bench for fp_cmp_stage: an independent reference model
// predicts each accepted op, and a negedge monitor checks results in order.
module tb_fp_cmp_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  tag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic [4:0]  tag_o;

    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    logic [41:0] sb[$];
    bit          held = 1'b0;
    logic [42:0] held_val;

    fp_cmp_stage #(.TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .fflags_o(fflags_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    // Monotone unsigned key: -0.0 maps just below +0.0.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [36:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = '0;
        logic [4:0]  f = '0;
        bit na = is_nan(a), nb = is_nan(b);
        bit sn = is_snan(a) || is_snan(b);
        bit bz = (a[30:0] == 0) && (b[30:0] == 0);
        case (op)
            3'd0, 3'd1: begin
                if (na && nb) r = 32'h7FC0_0000;
                else if (na)  r = b;
                else if (nb)  r = a;
                else if (op == 3'd0) r = (key(a) <= key(b)) ? a : b;
                else                 r = (key(a) >= key(b)) ? a : b;
                f[4] = sn;
            end
            3'd2: begin r[0] = !(na || nb) && (a == b || bz); f[4] = sn; end
            3'd3: begin r[0] = !(na || nb) && !bz && (key(a) < key(b)); f[4] = na || nb; end
            3'd4: begin r[0] = !(na || nb) && (bz || key(a) <= key(b)); f[4] = na || nb; end
            default: ;
        endcase
        return {r, f};
    endfunction

    always @(negedge clk) begin
        if (!rst_n || flush_i) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) check("stall_stable", {21'b0, out_valid_o, result_o, fflags_o, tag_o}, {21'b0, held_val});
            if (out_valid_o && out_ready_i) begin
                n_out++;
                if (sb.size() == 0) check("unexpected_out", {59'b0, tag_o}, 64'hFFFF);
                else check("result", {22'b0, result_o, fflags_o, tag_o}, {22'b0, sb.pop_front()});
            end
            held     = out_valid_o && !out_ready_i;
            held_val = {out_valid_o, result_o, fflags_o, tag_o};
            if (in_valid_i && in_ready_o) sb.push_back({model(op_i, rs1_i, rs2_i), tag_i});
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int  n = 0;
        bit  acc;
        op_i = op; rs1_i = a; rs2_i = b; tag_i = tag; in_valid_i = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 0, 1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", {63'b0, n >= 50}, 0);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'b0, out_valid_o}, 0);
        check("reset_result", {32'b0, result_o}, 0);
        check("reset_fflags", {59'b0, fflags_o}, 0);
        check("reset_tag", {59'b0, tag_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(3'd0, 32'h3F80_0000, 32'hC000_0000, 5'd1);
        check("lat_s1", {63'b0, out_valid_o}, 0);
        @(posedge clk);
        #1;
        check("lat_s2", {63'b0, out_valid_o}, 1);
        check("lat_result", {32'b0, result_o}, 64'hC000_0000);
        drain();

        send(3'd1, 32'h8000_0000, 32'h0000_0000, 5'd2);
        send(3'd0, 32'h8000_0000, 32'h0000_0000, 5'd3);
        send(3'd2, 32'h8000_0000, 32'h0000_0000, 5'd4);
        send(3'd0, 32'h7F80_0001, 32'h3F80_0000, 5'd5);
        send(3'd1, 32'h7FC0_0001, 32'hFFC0_0000, 5'd6);
        send(3'd3, 32'h7FC0_0000, 32'h3F80_0000, 5'd7);
        send(3'd2, 32'h7FC0_0000, 32'h3F80_0000, 5'd8);
        send(3'd4, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        send(3'd3, 32'hC000_0000, 32'hBF80_0000, 5'd10);
        send(3'd4, 32'h8000_0000, 32'h0000_0000, 5'd11);
        send(3'd3, 32'h8000_0000, 32'h0000_0000, 5'd12);
        send(3'd1, 32'hC000_0000, 32'hBF80_0000, 5'd13);
        send(3'd2, 32'h7F80_0001, 32'h7F80_0001, 5'd14);
        send(3'd7, 32'h3F80_0000, 32'h4000_0000, 5'd15);
        drain();

        base = n_out;
        out_ready_i = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(3'(i % 5), 32'h4000_0000 + 32'(i), 32'hC040_0000 - 32'(i), 5'(i));
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_in_ready_low", {63'b0, in_ready_o}, 0);
                out_ready_i = 1'b1;
            end
        join
        drain();
        check("stream_count", 64'(n_out - base), 6);

        base = n_out;
        out_ready_i = 1'b0;
        send(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd20);
        send(3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd21);
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_out_valid", {63'b0, out_valid_o}, 0);
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_output", 64'(n_out - base), 0);

        send(3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd22);
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {63'b0, out_valid_o}, 0);
        check("async_reset_result", {32'b0, result_o}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        send(3'd4, 32'hBF80_0000, 32'h3F80_0000, 5'd23);
        check("rst_lat_s1", {63'b0, out_valid_o}, 0);
        @(posedge clk);
        #1;
        check("rst_lat_s2", {63'b0, out_valid_o}, 1);
        drain();
        check("scoreboard_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
